// File: rtl/i2s_master_ctrl.sv
// Master-mode I2S bus sequencer: derives SCLK/WS from the system clock and
// provides clk-domain bit-edge, slot and frame strobes for rx/tx shift logic.
// Start/stop happen on frame boundaries; divider changes apply only at frame start.
module i2s_master_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIV_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [DIV_W-1:0]           div_i,
    output logic                       sclk_o,
    output logic                       ws_o,
    output logic                       sclkRise_o,
    output logic                       sclkFall_o,
    output logic [$clog2(2*WIDTH)-1:0] slot_o,
    output logic                       frameStart_o,
    output logic                       busy_o
);

    localparam int unsigned SlotW = $clog2(2*WIDTH);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(2*WIDTH-1);
    localparam logic [SlotW-1:0] SlotWsHi = SlotW'(WIDTH-1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_lat_q, div_lat_d;
    logic               sclk_q, sclk_d;
    logic               ws_q, ws_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               fs_q, fs_d;
    logic               busy_q, busy_d;
    logic [SlotW-1:0]   slot_q, slot_d;
    logic [SlotW-1:0]   slot_nxt;

    // Next-state: sequencing, half-period counter, SCLK/WS generation and strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_lat_d = div_lat_q;
        sclk_d    = sclk_q;
        ws_d      = ws_q;
        slot_d    = slot_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        fs_d      = 1'b0;
        slot_nxt  = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d   = StRun;
                    div_lat_d = div_i;
                    cnt_d     = '0;
                end
            end
            StRun, StDrain: begin
                if (state_q == StRun && !en_i) begin
                    state_d = StDrain;
                end else if (state_q == StDrain && en_i) begin
                    state_d = StRun;
                end

                if (cnt_q == div_lat_q) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rise_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        fall_d = 1'b1;
                        if (slot_q == SlotLast && state_q == StDrain && !en_i) begin
                            // Stop edge: SCLK parks low, slot holds, no frame start.
                            state_d = StIdle;
                            ws_d    = 1'b0;
                        end else begin
                            slot_d = slot_nxt;
                            if (slot_nxt == '0) begin
                                fs_d      = 1'b1;
                                div_lat_d = div_i;
                            end
                            // WS changes one bit ahead of the channel it selects.
                            if (slot_nxt == SlotWsHi) begin
                                ws_d = 1'b1;
                            end else if (slot_nxt == SlotLast) begin
                                ws_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers; async reset aborts any frame in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_lat_q <= '0;
            sclk_q    <= 1'b0;
            ws_q      <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            slot_q    <= SlotLast;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_lat_q <= div_lat_d;
            sclk_q    <= sclk_d;
            ws_q      <= ws_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
            slot_q    <= slot_d;
        end
    end

    assign sclk_o       = sclk_q;
    assign ws_o         = ws_q;
    assign sclkRise_o   = rise_q;
    assign sclkFall_o   = fall_q;
    assign slot_o       = slot_q;
    assign frameStart_o = fs_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2s_master_ctrl.sv
// Self-checking bench for i2s_master_ctrl: expected fall-edge events are queued
// when stimulus is planned and compared as the DUT produces them.
module tb_i2s_master_ctrl;

    localparam int W    = 16;
    localparam int SW   = 5;
    localparam int LAST = 2*W-1;

    typedef struct {
        logic [SW-1:0] slot;
        logic          ws;
        logic          fs;
        logic          busy;
        int            gap;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [7:0]    div;
    logic          sclk_o, ws_o, sclkRise_o, sclkFall_o, frameStart_o, busy_o;
    logic [SW-1:0] slot_o;

    int   cyc = 0;
    int   last_fall_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    i2s_master_ctrl #(.WIDTH(W), .DIV_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .div_i        (div),
        .sclk_o       (sclk_o),
        .ws_o         (ws_o),
        .sclkRise_o   (sclkRise_o),
        .sclkFall_o   (sclkFall_o),
        .slot_o       (slot_o),
        .frameStart_o (frameStart_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_frame(input int from, input int to, input int gap);
        exp_t e;
        for (int s = from; s <= to; s++) begin
            e.slot = SW'(s);
            e.ws   = (s >= W-1 && s <= 2*W-2);
            e.fs   = (s == 0);
            e.busy = 1'b1;
            e.gap  = gap;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_stop(input int gap);
        exp_t e;
        e.slot = SW'(LAST);
        e.ws   = 1'b0;
        e.fs   = 1'b0;
        e.busy = 1'b0;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Scoreboard consumer: every SCLK fall strobe is matched against the queue.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (frameStart_o || sclkFall_o) begin
                    checks++;
                    if (frameStart_o && !sclkFall_o) begin
                        errors++;
                        $display("FAIL frame_start_alone got fs=1 fall=0 required fall=1");
                    end
                end
                if (sclkFall_o) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_fall got slot=%0d required no edge", slot_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (slot_o !== e.slot) begin
                            errors++;
                            $display("FAIL fall_slot got %0d required %0d", slot_o, e.slot);
                        end
                        checks++;
                        if (ws_o !== e.ws) begin
                            errors++;
                            $display("FAIL fall_ws slot=%0d got %0b required %0b",
                                     e.slot, ws_o, e.ws);
                        end
                        checks++;
                        if (frameStart_o !== e.fs) begin
                            errors++;
                            $display("FAIL fall_framestart slot=%0d got %0b required %0b",
                                     e.slot, frameStart_o, e.fs);
                        end
                        checks++;
                        if (busy_o !== e.busy || sclk_o !== 1'b0) begin
                            errors++;
                            $display("FAIL fall_busy_sclk slot=%0d got busy=%0b sclk=%0b required %0b/0",
                                     e.slot, busy_o, sclk_o, e.busy);
                        end
                        checks++;
                        if ((cyc - last_fall_cyc) !== e.gap) begin
                            errors++;
                            $display("FAIL fall_period slot=%0d got %0d clk required %0d clk",
                                     e.slot, cyc - last_fall_cyc, e.gap);
                        end
                    end
                    last_fall_cyc = cyc;
                end
            end
        end
    endtask

    task automatic start_run(input logic [7:0] d);
        @(negedge clk);
        div = d;
        en  = 1'b1;
        last_fall_cyc = cyc + 1;
    endtask

    task automatic wait_slot(input int s);
        bit hit = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            if (sclkFall_o && busy_o && int'(slot_o) == s) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_slot_%0d got timeout required slot entry", s);
        end
    endtask

    task automatic wait_idle();
        bit hit = 1'b0;
        bit seen = 1'b0;
        for (int i = 0; i < 4000 && !hit; i++) begin
            @(negedge clk);
            if (!busy_o) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_idle got busy=1 required busy=0 within bound");
        end
        checks++;
        if (sclk_o !== 1'b0 || ws_o !== 1'b0 || int'(slot_o) != LAST) begin
            errors++;
            $display("FAIL idle_state got sclk=%0b ws=%0b slot=%0d required 0/0/%0d",
                     sclk_o, ws_o, slot_o, LAST);
        end
        repeat (20) begin
            @(negedge clk);
            if (sclkRise_o || sclkFall_o || frameStart_o || busy_o) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL idle_quiet got activity required none");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_edges got %0d left required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        div   = 8'd1;
        repeat (3) @(negedge clk);
        checks++;
        if (sclk_o !== 1'b0) begin errors++; $display("FAIL rst_sclk got %0b required 0", sclk_o); end
        checks++;
        if (ws_o !== 1'b0) begin errors++; $display("FAIL rst_ws got %0b required 0", ws_o); end
        checks++;
        if (sclkRise_o !== 1'b0 || sclkFall_o !== 1'b0) begin
            errors++; $display("FAIL rst_strobes got %0b%0b required 00", sclkRise_o, sclkFall_o);
        end
        checks++;
        if (frameStart_o !== 1'b0) begin errors++; $display("FAIL rst_fs got %0b required 0", frameStart_o); end
        checks++;
        if (int'(slot_o) != LAST) begin errors++; $display("FAIL rst_slot got %0d required %0d", slot_o, LAST); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b required 0", busy_o); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || sclk_o !== 1'b0 || int'(slot_o) != LAST) begin
            errors++;
            $display("FAIL idle_hold got busy=%0b sclk=%0b slot=%0d required 0/0/%0d",
                     busy_o, sclk_o, slot_o, LAST);
        end
    endtask

    task automatic test_run_stop();
        start_run(8'd1);
        push_frame(0, LAST, 4);
        push_frame(0, LAST, 4);
        push_stop(4);
        wait_slot(5);
        wait_slot(5);
        en = 1'b0;
        wait_idle();
    endtask

    task automatic test_reenable();
        start_run(8'd1);
        push_frame(0, LAST, 4);
        push_frame(0, LAST, 4);
        push_stop(4);
        wait_slot(5);
        en = 1'b0;
        wait_slot(20);
        en = 1'b1;
        wait_slot(5);
        en = 1'b0;
        wait_idle();
    endtask

    task automatic test_div_change();
        start_run(8'd1);
        push_frame(0, LAST, 4);
        push_frame(0, 0, 4);
        push_frame(1, LAST, 8);
        push_stop(8);
        wait_slot(8);
        div = 8'd3;
        wait_slot(5);
        en = 1'b0;
        wait_idle();
        div = 8'd1;
    endtask

    task automatic test_div0();
        bit hit = 1'b0;
        bit prev_rise;
        start_run(8'd0);
        push_frame(0, LAST, 2);
        push_stop(2);
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (sclkRise_o || sclkFall_o) hit = 1'b1;
        end
        checks++;
        if (!hit || sclkRise_o !== 1'b1) begin
            errors++;
            $display("FAIL div0_first_edge got rise=%0b required 1", sclkRise_o);
        end
        prev_rise = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (sclkRise_o !== !prev_rise || sclkFall_o !== prev_rise) begin
                errors++;
                $display("FAIL div0_alternate got rise=%0b fall=%0b required %0b/%0b",
                         sclkRise_o, sclkFall_o, !prev_rise, prev_rise);
            end
            prev_rise = sclkRise_o;
        end
        wait_slot(5);
        en = 1'b0;
        wait_idle();
        div = 8'd1;
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        start_run(8'd1);
        push_frame(0, LAST, 4);
        wait_slot(20);
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (sclk_o) hit = 1'b1;
        end
        checks++;
        if (!hit || ws_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got sclk=%0b ws=%0b required 1/1", sclk_o, ws_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sclk_o !== 1'b0 || ws_o !== 1'b0 || busy_o !== 1'b0 || int'(slot_o) != LAST ||
            sclkRise_o !== 1'b0 || sclkFall_o !== 1'b0 || frameStart_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got sclk=%0b ws=%0b busy=%0b slot=%0d required 0/0/0/%0d",
                     sclk_o, ws_o, busy_o, slot_o, LAST);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        last_fall_cyc = cyc + 1;
        push_frame(0, LAST, 4);
        push_stop(4);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (sclkRise_o || sclkFall_o) hit = 1'b1;
        end
        checks++;
        if (!hit || sclkRise_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_first_edge got rise=%0b fall=%0b required rise",
                     sclkRise_o, sclkFall_o);
        end
        wait_slot(5);
        en = 1'b0;
        wait_idle();
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_run_stop();
        test_reenable();
        test_div_change();
        test_div0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
